fetch_unit: RTL and testbench

- Parametrised instruction-fetch stage for the pipelined MIPS core.
- Holds the PC and a direct-mapped instruction cache, plus a refill FSM that fetches whole lines from instruction memory over a req/ack handshake.
- Presents one instruction per cycle to decode with a valid/stall handshake.
- Generalises the earlier fetch stage with configurable line size and cache depth, miss handling, branch redirect during a refill, decode back-pressure, and cache flush.

---
 rtl/fetch_pkg.sv | 15 +
 rtl/fetch_unit_icache_array.sv | 37 +++
 rtl/fetch_unit.sv | 92 +++++++++
 tb/tb_fetch_unit.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and address-split helpers for the instruction fetch stage
package fetch_pkg;
    typedef enum logic {RUN, REFILL} state_t;
    localparam int DEF_ADDR_W = 32;
    localparam int DEF_INSTR_W = 32;
    localparam int DEF_WORDS = 4;
    localparam int DEF_LINES = 16;
    localparam int OFF_W = 2 + $clog2(DEF_WORDS);
    localparam int IDX_W = $clog2(DEF_LINES);
    localparam int TAG_W = DEF_ADDR_W - OFF_W - IDX_W;
    typedef logic [DEF_WORDS*DEF_INSTR_W-1:0] line_t;
    function automatic int off_w(input int words);
        return 2 + $clog2(words);
    endfunction
endpackage

// File: rtl/fetch_unit_icache_array.sv
// icache_array: direct-mapped tag/valid/data store, combinational read, one write port, flush-all
module icache_array
    import fetch_pkg::*;
#(
    parameter int IW = IDX_W,
    parameter int TW = TAG_W,
    parameter int LW = $bits(line_t)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [IW-1:0] rd_idx,
    output logic          rd_valid,
    output logic [TW-1:0] rd_tag,
    output logic [LW-1:0] rd_line,
    input  logic          we,
    input  logic [IW-1:0] wr_idx,
    input  logic [TW-1:0] wr_tag,
    input  logic [LW-1:0] wr_line,
    input  logic          flush
);
    logic [(1<<IW)-1:0] valid;
    logic [TW-1:0]      tags [1<<IW];
    logic [LW-1:0]      data [1<<IW];
    // flush wins over a coincident fill so the refilled line stays invalid
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) valid <= '0;
        else if (flush) valid <= '0;
        else if (we) valid[wr_idx] <= 1'b1;
    always_ff @(posedge clk)
        if (we) begin
            tags[wr_idx] <= wr_tag;
            data[wr_idx] <= wr_line;
        end
    assign rd_valid = valid[rd_idx];
    assign rd_tag   = tags[rd_idx];
    assign rd_line  = data[rd_idx];
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC, direct-mapped I-cache and line-refill FSM feeding decode one instruction per cycle
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int INSTR_W = 32,
    parameter int WORDS_PER_LINE = 4,
    parameter int NUM_LINES = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [ADDR_W-1:0]           branch_target,
    input  logic                        pc_source,
    input  logic                        stall,
    input  logic                        icache_flush,
    output logic [INSTR_W-1:0]          instruction,
    output logic [ADDR_W-1:0]           instr_pc,
    output logic [ADDR_W-1:0]           next_pc,
    output logic                        instr_valid,
    output logic                        hit,
    output logic                        mem_req,
    output logic [ADDR_W-1:0]           mem_addr,
    input  logic                        mem_ack,
    input  logic [WORDS_PER_LINE*INSTR_W-1:0] mem_line
);
    localparam int OFF = off_w(WORDS_PER_LINE);
    localparam int IW  = $clog2(NUM_LINES);
    localparam int TW  = ADDR_W - OFF - IW;
    localparam int LW  = WORDS_PER_LINE * INSTR_W;
    state_t state, state_d;
    logic [ADDR_W-1:0] pc, pend_pc;
    logic pend, rd_valid;
    logic [TW-1:0] rd_tag;
    logic [LW-1:0] rd_line;
    icache_array #(.IW(IW), .TW(TW), .LW(LW)) u_array (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_idx   (pc[OFF+IW-1:OFF]),
        .rd_valid (rd_valid),
        .rd_tag   (rd_tag),
        .rd_line  (rd_line),
        .we       (state == REFILL && mem_ack),
        .wr_idx   (mem_addr[OFF+IW-1:OFF]),
        .wr_tag   (mem_addr[ADDR_W-1:OFF+IW]),
        .wr_line  (mem_line),
        .flush    (icache_flush)
    );
    assign hit = state == RUN && rd_valid && rd_tag == pc[ADDR_W-1:OFF+IW];
    assign next_pc = instr_pc + ADDR_W'(4);
    always_comb
        state_d = (state == RUN) ? ((pc_source || stall || hit) ? RUN : REFILL)
                                 : (mem_ack ? RUN : REFILL);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= RUN;
        else state <= state_d;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            pc          <= RESET_PC;
            pend        <= 1'b0;
            pend_pc     <= '0;
            instruction <= '0;
            instr_pc    <= '0;
            instr_valid <= 1'b0;
            mem_req     <= 1'b0;
            mem_addr    <= '0;
        end else if (state == RUN) begin
            if (pc_source) begin
                pc          <= branch_target;
                instr_valid <= 1'b0;
            end else if (!stall) begin
                if (hit) begin
                    instruction <= rd_line[pc[OFF-1:2]*INSTR_W +: INSTR_W];
                    instr_pc    <= pc;
                    instr_valid <= 1'b1;
                    pc          <= pc + ADDR_W'(4);
                end else begin
                    mem_req     <= 1'b1;
                    mem_addr    <= {pc[ADDR_W-1:OFF], {OFF{1'b0}}};
                    instr_valid <= 1'b0;
                end
            end
        end else if (mem_ack) begin
            // pc stays put without a redirect so the next cycle re-looks up and hits
            mem_req <= 1'b0;
            pend    <= 1'b0;
            pc      <= pc_source ? branch_target : pend ? pend_pc : pc;
        end else if (pc_source) begin
            pend    <= 1'b1;
            pend_pc <= branch_target;
        end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scoreboard bench; memory line k holds words k*4..k*4+3, so instruction == pc>>2
module tb_fetch_unit;
    logic clk = 0, rst_n = 0, pc_source = 0, stall = 0, icache_flush = 0, mem_ack = 0;
    logic [31:0] branch_target = 0;
    logic [127:0] mem_line = 0;
    logic [31:0] instruction, instr_pc, next_pc, mem_addr;
    logic instr_valid, hit, mem_req;

    fetch_unit #(.ADDR_W(32), .INSTR_W(32), .WORDS_PER_LINE(4), .NUM_LINES(16), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst_n(rst_n), .branch_target(branch_target), .pc_source(pc_source),
        .stall(stall), .icache_flush(icache_flush), .instruction(instruction), .instr_pc(instr_pc),
        .next_pc(next_pc), .instr_valid(instr_valid), .hit(hit), .mem_req(mem_req),
        .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_line(mem_line)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    logic [31:0] q[$];
    logic [31:0] reqs[$];
    logic busy = 0, mem_auto = 0, pv = 0;
    logic [31:0] raddr = 0, ppc = 0;
    int wt = 0, ack_delay = 0;

    typedef struct {
        logic        flush;
        logic [31:0] target;
        int          delay;
        int          n;
        int          nreq;
        logic [31:0] exp_addr;
    } vec_t;
    vec_t vecs[5];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    function automatic logic [127:0] mk_line(input logic [31:0] a);
        logic [127:0] l;
        logic [31:0] k;
        k = a >> 4;
        for (int i = 0; i < 4; i++) l[i*32 +: 32] = k * 4 + 32'(i);
        return l;
    endfunction

    // one clock: scoreboard new outputs, then act as instruction memory
    task automatic step();
        logic [31:0] e;
        @(posedge clk);
        #1;
        if (instr_valid && !(pv && instr_pc == ppc)) begin
            if (q.size() == 0) chk("unexpected_issue", instr_pc, 32'hxxxx_xxxx);
            else begin
                e = q.pop_front();
                chk("instr_pc", instr_pc, e);
                chk("instruction", instruction, e >> 2);
                chk("next_pc", next_pc, e + 32'd4);
            end
        end
        pv = instr_valid;
        ppc = instr_pc;
        mem_ack = 0;
        if (mem_req) begin
            chk("valid_in_refill", 32'(instr_valid), 0);
            if (!busy) begin
                busy = 1;
                raddr = mem_addr;
                wt = 0;
                reqs.push_back(mem_addr);
            end else chk("mem_addr_stable", mem_addr, raddr);
            if (mem_auto) begin
                if (wt >= ack_delay) begin
                    mem_ack = 1;
                    mem_line = mk_line(raddr);
                    busy = 0;
                end else wt++;
            end
        end else busy = 0;
    endtask

    task automatic drain(input int bound, output int n);
        n = 0;
        while (q.size() != 0 && n < bound) begin
            step();
            n++;
        end
        if (q.size() != 0) begin
            chk("drain_timeout", 32'(q.size()), 0);
            q.delete();
        end
    endtask

    task automatic wait_req(input int cnt, input int bound);
        int n = 0;
        while (reqs.size() < cnt && n < bound) begin
            step();
            n++;
        end
        chk("req_count", 32'(reqs.size()), 32'(cnt));
    endtask

    task automatic redirect(input logic [31:0] t);
        pc_source = 1;
        branch_target = t;
        step();
        pc_source = 0;
    endtask

    task automatic release_mem(input int d);
        mem_auto = 1;
        ack_delay = d;
        wt = 0;
    endtask

    task automatic run_vec(input vec_t v);
        int n0, c;
        n0 = reqs.size();
        if (v.flush) begin
            icache_flush = 1;
            step();
            icache_flush = 0;
        end
        for (int i = 0; i < v.n; i++) q.push_back(v.target + 32'(4 * i));
        redirect(v.target);
        release_mem(v.delay);
        drain(200, c);
        mem_auto = 0;
        wait_req(n0 + v.nreq, 20);
        chk("miss_addr", reqs[reqs.size()-1], v.exp_addr);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int c, n0;
        // redirect issued while a refill is pending; each leaves the FSM parked on a fresh miss
        vecs[0] = '{1'b0, 32'h0000_0020, 5, 4, 2, 32'h0000_0030};
        vecs[1] = '{1'b0, 32'h0000_0048, 0, 2, 2, 32'h0000_0050};
        vecs[2] = '{1'b0, 32'h0000_000C, 2, 21, 1, 32'h0000_0060};
        vecs[3] = '{1'b0, 32'hFFFF_FFF8, 1, 30, 2, 32'h0000_0070};
        vecs[4] = '{1'b1, 32'h0000_0000, 0, 4, 2, 32'h0000_0010};

        repeat (2) step();
        chk("rst_instr_valid", 32'(instr_valid), 0);
        chk("rst_instruction", instruction, 0);
        chk("rst_instr_pc", instr_pc, 0);
        chk("rst_next_pc", next_pc, 4);
        chk("rst_mem_req", 32'(mem_req), 0);
        chk("rst_mem_addr", mem_addr, 0);

        for (int i = 0; i < 4; i++) q.push_back(32'(4 * i));
        release_mem(0);
        rst_n = 1;
        drain(40, c);
        chk("burst_cycles", 32'(c), 6);
        mem_auto = 0;
        wait_req(2, 10);
        chk("first_miss", reqs[0], 0);
        chk("next_miss", reqs[1], 32'h10);

        for (int i = 0; i < 5; i++) run_vec(vecs[i]);

        n0 = reqs.size();
        for (int i = 0; i < 4; i++) q.push_back(32'(4 * i));
        redirect(0);
        release_mem(0);
        c = 0;
        while (!(instr_valid && instr_pc == 8) && c < 20) begin
            step();
            c++;
        end
        chk("reach_pc8", instr_pc, 8);
        stall = 1;
        repeat (3) begin
            step();
            chk("stall_pc", instr_pc, 8);
            chk("stall_instr", instruction, 2);
            chk("stall_valid", 32'(instr_valid), 1);
            chk("stall_hit", 32'(hit), 1);
        end
        stall = 0;
        step();
        chk("after_stall_pc", instr_pc, 32'hC);
        stall = 1;
        pc_source = 1;
        branch_target = 32'h80;
        mem_auto = 0;
        step();
        stall = 0;
        pc_source = 0;
        chk("stall_redirect_squash", 32'(instr_valid), 0);
        wait_req(n0 + 1, 10);
        chk("redirect_miss", reqs[reqs.size()-1], 32'h80);
        chk("hit_in_refill", 32'(hit), 0);

        n0 = reqs.size();
        release_mem(0);
        step();
        mem_auto = 0;
        icache_flush = 1;
        step();
        icache_flush = 0;
        wait_req(n0 + 1, 10);
        chk("flush_ack_remiss", reqs[reqs.size()-1], 32'h80);

        #2 rst_n = 0;
        #1;
        chk("async_req_drop", 32'(mem_req), 0);
        chk("async_valid_drop", 32'(instr_valid), 0);
        step();
        step();
        rst_n = 1;
        mem_ack = 1;
        mem_line = mk_line(32'h80);
        n0 = reqs.size();
        step();
        wait_req(n0 + 1, 10);
        chk("reset_miss_addr", reqs[reqs.size()-1], 0);
        for (int i = 0; i < 4; i++) q.push_back(32'(4 * i));
        release_mem(0);
        drain(40, c);
        mem_auto = 0;
        wait_req(n0 + 2, 10);
        chk("post_reset_next_miss", reqs[reqs.size()-1], 32'h10);

        chk("queue_empty", 32'(q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
